// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a core-side valid/ready request into one APB
// SETUP/ACCESS transfer and returns read data / slave error on a valid/ready
// response channel. One transaction in flight, no pipelining.
// Optional feature macro: APB_TIMEOUT_EN -- forces an error response when the
// slave holds pready low for TIMEOUT_CYC ACCESS cycles.
module apb_master_bridge #(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int TIMEOUT_CYC = 256,
    localparam int STRB_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              m_psel,
    output logic              m_penable,
    output logic [ADDR_W-1:0] m_paddr,
    output logic              m_pwrite,
    output logic [DATA_W-1:0] m_pwdata,
    output logic [STRB_W-1:0] m_pstrb,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // A timeout shorter than two cycles cannot be distinguished from a normal wait
    if (TIMEOUT_CYC < 2) begin : g_timeout_range
        $error("apb_master_bridge: TIMEOUT_CYC must be >= 2");
    end

`ifdef APB_TIMEOUT_EN
    logic [15:0] wait_cnt;
`endif

    // Transfer FSM; the APB bus fields double as the request latch, so they
    // naturally hold their last value between transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_rdy   <= 1'b1;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        m_paddr  <= req_addr;
                        m_pwrite <= req_wr;
                        m_pwdata <= req_wdata;
                        // Reads never drive strobes onto the bus
                        m_pstrb  <= req_wr ? req_wstrb : '0;
                        m_psel   <= 1'b1;
                        req_rdy  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    m_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (m_pready) begin
                        rsp_rdata <= m_pwrite ? '0 : m_prdata;
                        rsp_err   <= m_pslverr;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        rsp_vld   <= 1'b1;
                        state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    // pready on the expiry cycle is handled above and wins
                    else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        rsp_vld   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge. The bench plays the APB slave and
// the core, predicting every cycle of each transfer from the protocol rules.
module tb_apb_master_bridge;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 8;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [AW-1:0] req_addr = '0;
    logic          req_wr = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          m_psel;
    logic          m_penable;
    logic [AW-1:0] m_paddr;
    logic          m_pwrite;
    logic [DW-1:0] m_pwdata;
    logic [SW-1:0] m_pstrb;
    logic [DW-1:0] m_prdata = '0;
    logic          m_pready = 1'b0;
    logic          m_pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_wr(req_wr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
        .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Junk on the request side while busy and on the APB inputs outside ACCESS
    task automatic scramble(input bit keep_vld);
        req_vld   = keep_vld ? 1'b1 : 1'($urandom);
        req_addr  = $urandom;
        req_wr    = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = SW'($urandom);
        m_pready  = 1'($urandom);
        m_pslverr = 1'($urandom);
        m_prdata  = $urandom;
    endtask

    // One complete transfer, starting in an IDLE cycle and ending in the IDLE
    // cycle after the response handshake.
    task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input int waits, input logic [DW-1:0] prdata,
                          input logic slverr, input int hold, input bit keep_vld, input string nm);
        logic [AW+1+DW+SW-1:0] e_bus;
        logic [DW-1:0]         e_rdata;
        logic                  e_err;
        bit                    tmo;
        int                    n_acc;
        // Expected transfer, from the protocol rules
        tmo     = TO_EN && (waits >= TO_CYC);
        n_acc   = tmo ? TO_CYC : waits + 1;
        e_bus   = {addr, wr, wdata, (wr ? wstrb : SW'(0))};
        e_rdata = (tmo || wr) ? '0 : prdata;
        e_err   = tmo ? 1'b1 : slverr;

        checks++;
        if ({req_rdy, m_psel, m_penable, rsp_vld} !== 4'b1000) begin
            errors++;
            $display("FAIL %s idle_ctl got %b exp 1000", nm, {req_rdy, m_psel, m_penable, rsp_vld});
        end
        req_vld = 1'b1; req_addr = addr; req_wr = wr; req_wdata = wdata; req_wstrb = wstrb;
        m_pready = 1'b0;
        step();
        // SETUP
        checks++;
        if ({m_psel, m_penable, req_rdy, rsp_vld} !== 4'b1000) begin
            errors++;
            $display("FAIL %s setup_ctl got %b exp 1000", nm, {m_psel, m_penable, req_rdy, rsp_vld});
        end
        checks++;
        if ({m_paddr, m_pwrite, m_pwdata, m_pstrb} !== e_bus) begin
            errors++;
            $display("FAIL %s setup_bus got %h exp %h", nm, {m_paddr, m_pwrite, m_pwdata, m_pstrb}, e_bus);
        end
        scramble(keep_vld);
        step();
        // ACCESS, one cycle per wait state plus the completing cycle
        for (int i = 0; i < n_acc; i++) begin
            checks++;
            if ({m_psel, m_penable, req_rdy, rsp_vld} !== 4'b1100) begin
                errors++;
                $display("FAIL %s access_ctl[%0d] got %b exp 1100", nm, i,
                         {m_psel, m_penable, req_rdy, rsp_vld});
            end
            checks++;
            if ({m_paddr, m_pwrite, m_pwdata, m_pstrb} !== e_bus) begin
                errors++;
                $display("FAIL %s access_bus[%0d] got %h exp %h", nm, i,
                         {m_paddr, m_pwrite, m_pwdata, m_pstrb}, e_bus);
            end
            scramble(keep_vld);
            if (!tmo && i == n_acc - 1) begin
                m_pready = 1'b1; m_prdata = prdata; m_pslverr = slverr;
            end else begin
                m_pready = 1'b0;
            end
            step();
        end
        // RESP, held for 'hold' extra cycles
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({m_psel, m_penable, rsp_vld, req_rdy} !== 4'b0010) begin
                errors++;
                $display("FAIL %s resp_ctl[%0d] got %b exp 0010", nm, h,
                         {m_psel, m_penable, rsp_vld, req_rdy});
            end
            checks++;
            if ({rsp_rdata, rsp_err} !== {e_rdata, e_err}) begin
                errors++;
                $display("FAIL %s resp_data[%0d] got %h/%b exp %h/%b", nm, h, rsp_rdata, rsp_err,
                         e_rdata, e_err);
            end
            scramble(keep_vld);
            rsp_rdy = (h == hold);
            step();
        end
        // Back in IDLE; bus fields keep the last transfer's values
        rsp_rdy = 1'b0;
        if (!keep_vld) req_vld = 1'b0;
        m_pready = 1'b0;
        checks++;
        if ({rsp_vld, req_rdy, m_psel, m_penable} !== 4'b0100) begin
            errors++;
            $display("FAIL %s post_ctl got %b exp 0100", nm, {rsp_vld, req_rdy, m_psel, m_penable});
        end
        checks++;
        if ({m_paddr, m_pwrite, m_pwdata, m_pstrb} !== e_bus) begin
            errors++;
            $display("FAIL %s post_bus got %h exp %h", nm, {m_paddr, m_pwrite, m_pwdata, m_pstrb}, e_bus);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_rdy, rsp_vld, rsp_rdata, rsp_err, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb}
            !== {1'b1, {(1+DW+1+1+1+AW+1+DW+SW){1'b0}}}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b psel=%b pen=%b paddr=%h", req_rdy, rsp_vld,
                     m_psel, m_penable, m_paddr);
        end
        rst = 1'b0;
        // Stray pready while idle must not start anything
        m_pready = 1'b1;
        step();
        step();
        m_pready = 1'b0;
        checks++;
        if ({req_rdy, rsp_vld, m_psel} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle got %b exp 100", {req_rdy, rsp_vld, m_psel});
        end
    endtask

    task automatic test_directed();
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, "read_basic");
        do_txn(32'hA000_0004, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hCAFE_F00D, 1'b0, 0, 1'b0, "write_wait3");
        do_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 32'h5555_5555, 1'b1, 1, 1'b0, "read_slverr");
    endtask

    task automatic test_back_to_back();
        // req_vld stays high through a 5-cycle response stall; second SETUP
        // lands two cycles after the handshake
        do_txn(32'h0000_2000, 1'b1, 32'hAAAA_5555, 4'h3, 0, 32'h0, 1'b0, 5, 1'b1, "b2b_first");
        do_txn(32'h0000_2004, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        bit prev_keep = 1'b0;
        for (int n = 0; n < 24; n++) begin
            bit keep = 1'($urandom);
            if (!prev_keep) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
            end
            do_txn({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'($urandom), $urandom, SW'($urandom),
                   $urandom_range(0, 4), $urandom, 1'($urandom), $urandom_range(0, 3), keep, "random");
            prev_keep = keep;
        end
        req_vld = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        req_vld = 1'b1; req_addr = 32'h4000_0040; req_wr = 1'b0; req_wdata = '0; req_wstrb = '0;
        step();
        req_vld = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_psel, m_penable, rsp_vld} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async got %b exp 000", {m_psel, m_penable, rsp_vld});
        end
        m_pready = 1'b1; m_prdata = 32'h1357_9BDF;
        step();
        #3 rst = 1'b0;
        step();
        checks++;
        if ({req_rdy, rsp_vld, m_psel, m_penable} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_release got %b exp 1000", {req_rdy, rsp_vld, m_psel, m_penable});
        end
        for (int i = 0; i < 3; i++) step();
        m_pready = 1'b0;
        checks++;
        if (rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stale got rsp_vld=%b exp 0", rsp_vld);
        end
    endtask

    task automatic test_timeout();
        // Completes on the last allowed cycle: pready wins over expiry
        do_txn(32'h0000_3000, 1'b0, 32'h0, 4'h0, TO_CYC - 1, 32'h7777_8888, 1'b0, 0, 1'b0, "to_edge");
        // One cycle later: times out when enabled, ordinary wait otherwise
        do_txn(32'h0000_3004, 1'b0, 32'h0, 4'h0, TO_CYC, 32'h9999_AAAA, 1'b0, 0, 1'b0, "to_expire");
        do_txn(32'h0000_3008, 1'b1, 32'h1111_2222, 4'h5, 20, 32'h0, 1'b0, 1, 1'b0, "to_long");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
